// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter family.
//   arb_state_t : arbiter FSM states
//   DATA_W_DEF  : default data word width
//   TIMEOUT_DEF : default per-state timeout in cycles
//   idx_w()     : width needed to index n items (never less than 1)
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational round-robin picker.
// Rotates the request vector so that index ptr sits at bit 0, picks the
// lowest set bit, then maps that offset back to an absolute index.
//   req    : request vector, one bit per requester
//   ptr    : highest-priority index for this pick
//   valid  : at least one request is present
//   winner : absolute index of the chosen requester (0 when !valid)
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [W-1:0]   offset;
  logic [W:0]     sum;

  // Doubling the vector makes the rotation a plain part-select.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N];

  // Scanning downward lets the lowest set offset win.
  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = W'(i);
      end
    end
  end

  assign sum    = {1'b0, ptr} + {1'b0, offset};
  assign winner = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  assign valid  = |req;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one four-phase send/ack bus channel among
// N_REQ requesters, with a per-state timeout so a dead slave cannot lock
// out every requester.
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-low reset
//   req_send    : per-requester request level
//   req_dado    : packed request data, requester i at [i*DATA_W +: DATA_W]
//   req_ack     : one-cycle completion pulse to the granted requester
//   bus_send    : registered request to the bus slave
//   bus_dado    : registered data to the bus slave
//   bus_ack     : four-phase acknowledge from the bus slave
//   grant_id    : index of the current or last grantee
//   busy        : high while in SEND or RELEASE
//   timeout_err : one-cycle pulse when a transaction is aborted
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IDX_W   = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_send,
  input  logic [N_REQ*DATA_W-1:0] req_dado,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    bus_send,
  output logic [DATA_W-1:0]       bus_dado,
  input  logic                    bus_ack,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CNT_W = idx_w(TIMEOUT);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  tcnt, tcnt_nxt;
  logic [IDX_W-1:0]  grant_nxt;
  logic [DATA_W-1:0] dado_nxt;
  logic              send_nxt;
  logic [N_REQ-1:0]  ack_nxt;
  logic              terr_nxt;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_winner;
  logic              tmo;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req    (req_send),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // tcnt counts cycles already spent in the current state, so the abort
  // fires on the TIMEOUT-th cycle without an acceptable bus_ack.
  assign tmo  = (tcnt == CNT_W'(TIMEOUT - 1));
  assign busy = (state == SEND) || (state == RELEASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      tcnt        <= '0;
      grant_id    <= '0;
      bus_dado    <= '0;
      bus_send    <= 1'b0;
      req_ack     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      tcnt        <= tcnt_nxt;
      grant_id    <= grant_nxt;
      bus_dado    <= dado_nxt;
      bus_send    <= send_nxt;
      req_ack     <= ack_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = SEND;
      SEND: begin
        if (bus_ack)  state_nxt = RELEASE;
        else if (tmo) state_nxt = IDLE;
      end
      RELEASE: begin
        if (!bus_ack) state_nxt = IDLE;
        else if (tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The pointer only moves when a transaction ends, so a requester that
  // loses keeps its place relative to the rotation.
  always_comb begin
    ptr_nxt   = ptr;
    tcnt_nxt  = tcnt;
    grant_nxt = grant_id;
    dado_nxt  = bus_dado;
    send_nxt  = bus_send;
    ack_nxt   = '0;
    terr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_winner;
          dado_nxt  = req_dado[int'(pick_winner)*DATA_W +: DATA_W];
          send_nxt  = 1'b1;
          tcnt_nxt  = '0;
        end
      end
      SEND: begin
        if (bus_ack) begin
          send_nxt          = 1'b0;
          ack_nxt[grant_id] = 1'b1;
          tcnt_nxt          = '0;
        end else if (tmo) begin
          send_nxt = 1'b0;
          terr_nxt = 1'b1;
          ptr_nxt  = next_idx(grant_id);
          tcnt_nxt = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!bus_ack) begin
          ptr_nxt  = next_idx(grant_id);
          tcnt_nxt = '0;
        end else if (tmo) begin
          terr_nxt = 1'b1;
          ptr_nxt  = next_idx(grant_id);
          tcnt_nxt = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: begin
        send_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (N_REQ=4, DATA_W=16, TIMEOUT=8).
// A transaction-level model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_bus_arbiter_rr;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int TMO  = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_send;
  logic [NREQ*DW-1:0] req_dado;
  logic [NREQ-1:0]   req_ack;
  logic              bus_send;
  logic [DW-1:0]     bus_dado;
  logic              bus_ack;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side bus slave and requester bookkeeping
  bit   slave_en  = 1'b1;
  int   ack_delay = 2;
  int   scnt      = 0;
  bit   auto_drop = 1'b1;
  logic prev_send = 1'b0;
  int   grants[$];
  logic [NREQ-1:0] acks[$];

  bus_arbiter_rr #(
    .N_REQ   (NREQ),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_send    (req_send),
    .req_dado    (req_dado),
    .req_ack     (req_ack),
    .bus_send    (bus_send),
    .bus_dado    (bus_dado),
    .bus_ack     (bus_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is either absent, waiting for bus_ack, or waiting
  // for bus_ack to fall; elapsed counts cycles spent waiting in that phase.
  int              m_ptr, m_grant, m_elapsed;
  bit              m_in_txn, m_acked, m_send, m_terr;
  logic [DW-1:0]   m_dado;
  logic [NREQ-1:0] m_ack;

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int p);
    int w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && r[(p + k) % NREQ]) w = (p + k) % NREQ;
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr <= 0; m_grant <= 0; m_elapsed <= 0;
      m_in_txn <= 1'b0; m_acked <= 1'b0; m_send <= 1'b0; m_terr <= 1'b0;
      m_dado <= '0; m_ack <= '0;
    end else begin
      m_ack  <= '0;
      m_terr <= 1'b0;
      if (!m_in_txn) begin
        if (rr_winner(req_send, m_ptr) >= 0) begin
          m_in_txn  <= 1'b1;
          m_acked   <= 1'b0;
          m_grant   <= rr_winner(req_send, m_ptr);
          m_dado    <= req_dado[rr_winner(req_send, m_ptr)*DW +: DW];
          m_send    <= 1'b1;
          m_elapsed <= 0;
        end
      end else if (!m_acked && bus_ack) begin
        m_acked   <= 1'b1;
        m_send    <= 1'b0;
        m_ack     <= NREQ'(1 << m_grant);
        m_elapsed <= 0;
      end else if (m_acked && !bus_ack) begin
        m_in_txn <= 1'b0;
        m_ptr    <= (m_grant + 1) % NREQ;
      end else if (m_elapsed + 1 == TMO) begin
        m_in_txn <= 1'b0;
        m_send   <= 1'b0;
        m_terr   <= 1'b1;
        m_ptr    <= (m_grant + 1) % NREQ;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    checkOutput("cyc_bus_send", 32'(bus_send), 32'(m_send));
    checkOutput("cyc_bus_dado", 32'(bus_dado), 32'(m_dado));
    checkOutput("cyc_grant_id", 32'(grant_id), 32'(m_grant));
    checkOutput("cyc_busy", 32'(busy), 32'(m_in_txn));
    checkOutput("cyc_req_ack", 32'(req_ack), 32'(m_ack));
    checkOutput("cyc_timeout_err", 32'(timeout_err), 32'(m_terr));
  end

  // One cycle of bench activity at the falling edge: record grants and
  // acks, let requesters drop on ack, and run the four-phase slave.
  task automatic tick();
    @(negedge clk);
    if (bus_send && !prev_send) grants.push_back(int'(grant_id));
    prev_send = bus_send;
    if (req_ack != '0) begin
      acks.push_back(req_ack);
      if (auto_drop) req_send = req_send & ~req_ack;
    end
    if (!slave_en || !bus_send) begin
      bus_ack = 1'b0;
      scnt    = 0;
    end else if (!bus_ack) begin
      scnt++;
      if (scnt >= ack_delay) bus_ack = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqs, input bit drop);
    auto_drop = drop;
    req_send  = reqs;
  endtask

  task automatic wait_acks(input int target, input int budget, input string tag);
    int n = 0;
    while (acks.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(acks.size()), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic clear_logs();
    grants.delete();
    acks.delete();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};
    rst = 1'b0; req_send = '0; req_dado = '0; bus_ack = 1'b0;
    tick();
    checkOutput("rst_bus_send", 32'(bus_send), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_bus_dado", 32'(bus_dado), 32'd0);
    checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] fairness, all requesters held high");
    clear_logs(); ack_delay = 2;
    applyStimulus(4'b1111, 1'b0);
    wait_acks(5, 100, "fair_ack_count");
    req_send = '0;
    checkOutput("fair_grant_count", 32'(grants.size()), 32'd5);
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      checkOutput("fair_grant_order", 32'(grants[k]), 32'(fair_exp[k]));
      checkOutput("fair_ack_onehot", 32'(acks[k]), 32'(1 << fair_exp[k]));
    end
    wait_idle("fair_idle");

    $display("[TB] single request from requester 2");
    clear_logs(); ack_delay = 3;
    req_dado[2*DW +: DW] = 16'hBEEF;
    applyStimulus(4'b0100, 1'b1);
    tick();
    checkOutput("single_latency", 32'(bus_send), 32'd1);
    checkOutput("single_grant", 32'(grant_id), 32'd2);
    checkOutput("single_dado", 32'(bus_dado), 32'hBEEF);
    wait_acks(1, 20, "single_ack_seen");
    if (acks.size() > 0) checkOutput("single_ack", 32'(acks[0]), 32'b0100);
    wait_idle("single_idle");

    $display("[TB] rotation wrap from pointer 3");
    clear_logs(); ack_delay = 2;
    applyStimulus(4'b1001, 1'b1);
    wait_acks(2, 40, "wrap_ack_count");
    if (grants.size() >= 2) begin
      checkOutput("wrap_first", 32'(grants[0]), 32'd3);
      checkOutput("wrap_second", 32'(grants[1]), 32'd0);
    end
    wait_idle("wrap_idle");

    clear_logs();
    applyStimulus(4'b0011, 1'b1);
    wait_acks(2, 40, "ptr1_ack_count");
    if (grants.size() >= 2) begin
      checkOutput("ptr1_first", 32'(grants[0]), 32'd1);
      checkOutput("ptr1_second", 32'(grants[1]), 32'd0);
    end
    wait_idle("ptr1_idle");

    $display("[TB] timeout with silent slave");
    clear_logs(); slave_en = 1'b0;
    applyStimulus(4'b0001, 1'b1);
    tick();
    n = 0;
    while (bus_send && n < 30) begin
      n++;
      tick();
    end
    checkOutput("tmo_send_cycles", 32'(n), 32'd8);
    checkOutput("tmo_err_pulse", 32'(timeout_err), 32'd1);
    checkOutput("tmo_busy", 32'(busy), 32'd0);
    checkOutput("tmo_no_ack", 32'(acks.size()), 32'd0);
    slave_en = 1'b1; ack_delay = 2;
    tick();
    checkOutput("tmo_regrant_send", 32'(bus_send), 32'd1);
    checkOutput("tmo_regrant_id", 32'(grant_id), 32'd0);
    wait_acks(1, 20, "tmo_final_ack");
    if (acks.size() > 0) checkOutput("tmo_final_ackval", 32'(acks[0]), 32'b0001);
    wait_idle("tmo_idle");

    $display("[TB] data stability while sending");
    clear_logs(); ack_delay = 4;
    req_dado[1*DW +: DW] = 16'h1111;
    applyStimulus(4'b0010, 1'b1);
    tick();
    checkOutput("data_send", 32'(bus_send), 32'd1);
    req_dado[1*DW +: DW] = 16'h2222;
    n = 0;
    while (bus_send && n < 20) begin
      checkOutput("data_stable", 32'(bus_dado), 32'h1111);
      tick();
      n++;
    end
    wait_acks(1, 20, "data_ack");
    wait_idle("data_idle");

    $display("[TB] asynchronous reset mid-transaction");
    clear_logs(); slave_en = 1'b0;
    applyStimulus(4'b0100, 1'b1);
    tick();
    checkOutput("arst_pre_send", 32'(bus_send), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_bus_send", 32'(bus_send), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_req_ack", 32'(req_ack), 32'd0);
    checkOutput("arst_grant", 32'(grant_id), 32'd0);
    req_send = 4'b0101;
    tick();
    tick();
    rst = 1'b1;
    clear_logs(); slave_en = 1'b1; ack_delay = 2;
    tick();
    checkOutput("arst_first_send", 32'(bus_send), 32'd1);
    checkOutput("arst_first_grant", 32'(grant_id), 32'd0);
    wait_acks(2, 40, "arst_acks");
    if (grants.size() >= 2) begin
      checkOutput("arst_order0", 32'(grants[0]), 32'd0);
      checkOutput("arst_order1", 32'(grants[1]), 32'd2);
    end
    wait_idle("arst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Shares the single processor-to-bus send/ack channel among N_REQ processor FSMs, each of which drives a data word plus a send request.
- Picks one requester per transaction by round-robin and forwards its registered data with bus_send.
- Waits for the bus handshake to complete, then returns a one-cycle ack to the winning requester.
- A per-transaction timeout keeps a dead bus from locking out every requester.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 16, data word width
TIMEOUT, 255, cycles allowed in SEND or RELEASE before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_send  in  N_REQ  per-requester request level; held high with stable data until req_ack
req_dado  in  N_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ack  out  N_REQ  one-cycle completion pulse to the granted requester
bus_send  out  1  request to bus slave (registered)
bus_dado  out  DATA_W  data to bus slave (registered; stable while bus_send=1)
bus_ack  in  1  bus slave acknowledge, four-phase
grant_id  out  clog2(N_REQ)  index of current/last grantee
busy  out  1  high in SEND or RELEASE
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset (rst=0, async) values: state=IDLE, ptr=0, bus_send=0, bus_dado=0, req_ack=0, grant_id=0, busy=0, timeout_err=0, tcnt=0.
- States: IDLE, SEND, RELEASE.
- IDLE:
  - If any req_send bit is set, winner = first i in ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ) with req_send[i]=1.
  - Next edge: grant_id<=winner, bus_dado<=req_dado[winner], bus_send<=1, tcnt<=0, state<=SEND.
  - Latency from request to bus_send: 1 cycle.
- SEND:
  - bus_ack=1 sampled: next edge bus_send<=0, req_ack[grant_id]<=1 for exactly one cycle, tcnt<=0, state<=RELEASE.
  - Otherwise tcnt increments. If tcnt==TIMEOUT-1 and bus_ack=0: bus_send<=0, timeout_err<=1 for one cycle, ptr<=grant_id+1 mod N_REQ, state<=IDLE. No req_ack is given on timeout.
- RELEASE:
  - Waits for bus_ack=0. On the first sampled 0: ptr<=grant_id+1 mod N_REQ, state<=IDLE.
  - Minimum 1 cycle in RELEASE.
  - Timeout counted the same way as in SEND; on timeout, pulse timeout_err, advance ptr, go to IDLE.
- Requester rule: req_send drops no later than the cycle after req_ack. The arbiter re-arbitrates from IDLE, so a stale request only wins if it is next in rotation.
- bus_dado never changes while bus_send=1. req_dado changes after latching are ignored.
- A req_send bit that drops while the arbiter is in SEND does not abort the transaction.
- Simultaneous requests: the rotation order is the only tie-break. Each requester waits at most N_REQ-1 transactions.
- busy=1 exactly when state is SEND or RELEASE. grant_id holds its value in IDLE.
- ptr wraps from N_REQ-1 to 0.
- rst asserted mid-transaction: all outputs return to reset values immediately; no req_ack is issued.

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, SEND, RELEASE}
  - localparam defaults DATA_W_DEF=16 and TIMEOUT_DEF=255
  - a clog2-based width helper
- Sub-module rr_pick (combinational): inputs req and ptr; outputs valid and winner index. It is the rotate, priority-encode, un-rotate step, and is reusable by later arbiters.
- The FSM, counter and registers stay in bus_arbiter_rr.

Test Plan:
- Single request: req_send=4'b0100, req_dado[2]=16'hBEEF, bus_ack rises 3 cycles after bus_send.
  -> bus_send=1 one cycle after the request, bus_dado=16'hBEEF, grant_id=2.
  -> req_ack=4'b0100 pulse the cycle after bus_ack is sampled high.
  -> back in IDLE after bus_ack falls; ptr=3.
- Fairness: all four req_send held high, slave acks each transaction in 2 cycles.
  -> grant order 0,1,2,3,0.
  -> exactly one req_ack bit set per transaction.
- Rotation wrap: ptr=3, req_send=4'b1001.
  -> requester 3 wins first, then 0.
  -> ptr goes 0 then 1.
- Timeout: TIMEOUT=8, bus_ack tied 0, req_send=4'b0001.
  -> bus_send high for 8 cycles, then timeout_err pulses once, busy=0, no req_ack.
  -> request 0 is re-granted on the next arbitration.
- Async reset mid-SEND: drive rst=0 between clock edges.
  -> bus_send, busy and req_ack are 0 before the next edge.
  -> after release, ptr=0 and requester 0 wins first.
- Data stability: change req_dado[1] from 16'h1111 to 16'h2222 while in SEND for requester 1.
  -> bus_dado stays 16'h1111 until bus_send deasserts.
